// File: rtl/ir_encoder.sv
// Serial IR transmitter: idle-high line, low start pulse, 32 bits MSB first at a fixed bit period.
// Optional macro IR_TX_CARRIER_EN: modulate ir_led with a carrier during marks instead of ~ir_signal.
module ir_encoder #(
    parameter int BIT_TICKS    = 1001,
    parameter int START_TICKS  = 500,
    parameter int TAIL_TICKS   = 503,
    parameter int GAP_TICKS    = 2000,
    parameter int CARRIER_HALF = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        ir_signal,
    output logic        ir_led
);

    localparam int MAX_BG    = (BIT_TICKS > GAP_TICKS) ? BIT_TICKS : GAP_TICKS;
    localparam int MAX_TICKS = (MAX_BG > START_TICKS) ? MAX_BG : START_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TW-1:0] START_LAST = TW'(START_TICKS - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TAIL_LAST  = TW'(TAIL_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [4:0]    bit_idx, bit_idx_nxt;
    logic [31:0]   shift, shift_nxt;
    logic          ir_nxt, ready_nxt, done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            ir_signal <= 1'b1;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            ir_signal <= ir_nxt;
            tx_ready  <= ready_nxt;
            tx_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        ir_nxt      = ir_signal;
        ready_nxt   = tx_ready;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_nxt = START;
                    shift_nxt = tx_data;
                    ir_nxt    = 1'b0;
                    ready_nxt = 1'b0;
                    timer_nxt = '0;
                end
            end
            START: begin
                if (timer == START_LAST) begin
                    state_nxt   = DATA;
                    timer_nxt   = '0;
                    bit_idx_nxt = '0;
                    ir_nxt      = shift[31];
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DATA: begin
                // The last bit is cut short so the line is already high when the decoder re-arms.
                if (bit_idx == 5'd31) begin
                    if (timer == TAIL_LAST) begin
                        state_nxt = GAP;
                        timer_nxt = '0;
                        ir_nxt    = 1'b1;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end else if (timer == BIT_LAST) begin
                    shift_nxt   = {shift[30:0], 1'b0};
                    bit_idx_nxt = bit_idx + 5'd1;
                    ir_nxt      = shift[30];
                    timer_nxt   = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef IR_TX_CARRIER_EN
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] carrier_cnt;

    // Carrier phase restarts at every high-to-low transition of the line so each mark begins lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carrier_cnt <= '0;
            ir_led      <= 1'b0;
        end else if (!ir_nxt) begin
            if (ir_signal) begin
                carrier_cnt <= '0;
                ir_led      <= 1'b1;
            end else if (carrier_cnt == CAR_LAST) begin
                carrier_cnt <= '0;
                ir_led      <= ~ir_led;
            end else begin
                carrier_cnt <= carrier_cnt + CW'(1);
            end
        end else begin
            carrier_cnt <= '0;
            ir_led      <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_led <= 1'b0;
        end else begin
            ir_led <= ~ir_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ir_encoder.sv
// Scoreboard bench for ir_encoder with shortened timing; a monitor captures each frame
// and compares it against a waveform model of the queued word.
module tb_ir_encoder;

    localparam int BT = 11;
    localparam int ST = 5;
    localparam int TT = 7;
    localparam int GT = 20;
    localparam int DONE_IDX = ST + 31 * BT + TT + GT;
    localparam int NS = DONE_IDX + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_done, ir_signal, ir_led;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int frames_seen = 0;
    int frame_start_cyc = 0;
    logic mon_en = 1'b0;
    logic [31:0] exp_q[$];

    logic line_s [NS];
    logic done_s [NS];
    logic ready_s[NS];
    logic led_s  [NS];

    ir_encoder #(
        .BIT_TICKS(BT), .START_TICKS(ST), .TAIL_TICKS(TT), .GAP_TICKS(GT), .CARRIER_HALF(13)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .ir_signal(ir_signal), .ir_led(ir_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_line(input logic [31:0] w, input int i);
        if (i < ST) return 1'b0;
        if (i < ST + 31 * BT) return w[31 - (i - ST) / BT];
        if (i < ST + 31 * BT + TT) return w[0];
        return 1'b1;
    endfunction

    task automatic monitor();
        int idx;
        logic in_frame;
        logic [31:0] w, got;
        int line_err, ctl_err, led_err, first_bad;
        in_frame = 1'b0;
        idx = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && ir_signal === 1'b0) begin
                    in_frame = 1'b1;
                    idx = 0;
                    frame_start_cyc = cyc;
                end
                if (in_frame) begin
                    line_s[idx]  = ir_signal;
                    done_s[idx]  = tx_done;
                    ready_s[idx] = tx_ready;
                    led_s[idx]   = ir_led;
                    idx++;
                    if (idx == NS) begin
                        in_frame = 1'b0;
                        frames_seen++;
                        if (exp_q.size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("[TB] FAIL unexpected_frame: frame at cycle %0d, none queued", frame_start_cyc);
                        end else begin
                            w = exp_q.pop_front();
                            line_err = 0; ctl_err = 0; led_err = 0; first_bad = -1;
                            for (int i = 0; i < NS; i++) begin
                                if (line_s[i] !== exp_line(w, i)) begin
                                    line_err++;
                                    if (first_bad < 0) first_bad = i;
                                end
                                if (done_s[i] !== (i == DONE_IDX) || ready_s[i] !== (i == DONE_IDX)) ctl_err++;
`ifdef IR_TX_CARRIER_EN
                                if (line_s[i] === 1'b1 && led_s[i] !== 1'b0) led_err++;
`else
                                if (led_s[i] !== ~line_s[i]) led_err++;
`endif
                            end
                            for (int b = 0; b < 31; b++) got[31 - b] = line_s[ST + b * BT + BT / 2];
                            got[0] = line_s[ST + 31 * BT + TT / 2];
                            tests_run++;
                            if (line_err !== 0) begin
                                tests_failed++;
                                $display("[TB] FAIL frame_line %h: %0d bad cycles, first at %0d, want 0", w, line_err, first_bad);
                            end
                            tests_run++;
                            if (got !== w) begin
                                tests_failed++;
                                $display("[TB] FAIL frame_data: got %h want %h", got, w);
                            end
                            tests_run++;
                            if (ctl_err !== 0) begin
                                tests_failed++;
                                $display("[TB] FAIL frame_done_ready %h: %0d bad cycles, want only cycle %0d high", w, ctl_err, DONE_IDX);
                            end
                            tests_run++;
                            if (led_err !== 0) begin
                                tests_failed++;
                                $display("[TB] FAIL frame_led %h: %0d bad cycles, want 0", w, led_err);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 2 * NS) begin
            @(negedge clk);
            n++;
        end
        tx_data = w;
        tx_valid = 1'b1;
        exp_q.push_back(w);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = $urandom;
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL accept_ready_low: tx_ready=%b want 0", tx_ready);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3 * NS) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_timeout: %0d frames pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int lows, dones;
        mon_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run += 4;
        if (ir_signal !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_line: %b want 1", ir_signal); end
        if (tx_ready !== 1'b1)  begin tests_failed++; $display("[TB] FAIL reset_ready: %b want 1", tx_ready); end
        if (tx_done !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_done: %b want 0", tx_done); end
        if (ir_led !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_led: %b want 0", ir_led); end
        reset = 1'b0;
        @(negedge clk);
        tx_data = 32'hA5A5_0F01;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tests_run++;
        if (ir_signal !== 1'b0) begin tests_failed++; $display("[TB] FAIL start_low: %b want 0", ir_signal); end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run += 3;
        if (ir_signal !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_line: %b want 1", ir_signal); end
        if (tx_ready !== 1'b1)  begin tests_failed++; $display("[TB] FAIL midreset_ready: %b want 1", tx_ready); end
        if (tx_done !== 1'b0)   begin tests_failed++; $display("[TB] FAIL midreset_done: %b want 0", tx_done); end
        @(negedge clk);
        reset = 1'b0;
        lows = 0; dones = 0;
        for (int i = 0; i < NS + 20; i++) begin
            @(negedge clk);
            if (ir_signal !== 1'b1) lows++;
            if (tx_done !== 1'b0) dones++;
        end
        tests_run += 2;
        if (lows !== 0)  begin tests_failed++; $display("[TB] FAIL abandon_line: %0d low cycles want 0", lows); end
        if (dones !== 0) begin tests_failed++; $display("[TB] FAIL abandon_done: %0d pulses want 0", dones); end
        mon_en = 1'b1;
    endtask

    task automatic test_single_frames();
        logic [31:0] words[3];
        words[0] = 32'hA5A5_0F01;
        words[1] = 32'h8000_0000;
        words[2] = 32'h7FFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            send_word(words[k]);
            wait_drain();
        end
    endtask

    task automatic test_back_to_back();
        int n, d1, f0;
        f0 = frames_seen;
        @(negedge clk);
        tx_data = 32'h0000_0001;
        tx_valid = 1'b1;
        exp_q.push_back(32'h0000_0001);
        @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_first_accept: tx_ready=%b want 0", tx_ready); end
        tx_data = 32'hFFFF_FFFF;
        exp_q.push_back(32'hFFFF_FFFF);
        n = 0;
        while (tx_done !== 1'b1 && n < 2 * NS) begin
            @(negedge clk);
            n++;
        end
        d1 = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
        tests_run += 2;
        if (ir_signal !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_restart_line: %b want 0", ir_signal); end
        if (tx_ready !== 1'b0)  begin tests_failed++; $display("[TB] FAIL b2b_restart_ready: %b want 0", tx_ready); end
        wait_drain();
        tests_run++;
        if (frame_start_cyc !== d1 + 1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_gap: second start cycle %0d want %0d", frame_start_cyc, d1 + 1);
        end
        repeat (NS + 10) @(negedge clk);
        tests_run++;
        if (frames_seen - f0 !== 2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_frame_count: %0d frames want 2", frames_seen - f0);
        end
    endtask

    task automatic test_ignore_midframe();
        int f0;
        f0 = frames_seen;
        send_word(32'h3C3C_C3C3);
        repeat (100) @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 32'hC3C3_3C3C;
        @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL data_ready_low: %b want 0", tx_ready); end
        tx_valid = 1'b0;
        tx_data = 32'h1234_5678;
        repeat (258) @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 32'hFFFF_0000;
        @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL gap_ready_low: %b want 0", tx_ready); end
        tx_valid = 1'b0;
        wait_drain();
        repeat (NS + 10) @(negedge clk);
        tests_run++;
        if (frames_seen - f0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL ignore_frame_count: %0d frames want 1", frames_seen - f0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_ignore_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
